// File: rtl/cmip_fifo_drain_arb_pkg.sv
// Shared state encoding and round-robin helper for the FIFO drain arbiter.
package cmip_fifo_drain_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Start position for the next search: one past the channel just served.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num);
        if (ptr >= num - 32'd1) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/cmip_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module cmip_rr_pick #(
    parameter int CH_NUM  = 32,
    parameter int CH_WDTH = $clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0]  i_req,
    input  logic [CH_WDTH-1:0] i_ptr,
    output logic [CH_WDTH-1:0] o_idx,
    output logic               o_found
);

    logic [2*CH_NUM-1:0] w_req_dbl;
    logic [2*CH_NUM-1:0] w_masked;
    logic [CH_WDTH:0]    w_pos;

    assign w_req_dbl = {i_req, i_req};
    assign o_found   = |i_req;

    // Lower copy drops bits below ptr; the upper copy provides the wrapped search.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < 2*CH_NUM; i++) begin
            w_masked[i] = (i >= CH_NUM || i >= int'(i_ptr)) ? w_req_dbl[i] : 1'b0;
        end
    end

    // Lowest set bit of the masked vector, folded back into channel range.
    always_comb begin
        w_pos = '0;
        for (int i = 2*CH_NUM-1; i >= 0; i--) begin
            w_pos = w_masked[i] ? (CH_WDTH+1)'(i) : w_pos;
        end
        if (w_pos >= (CH_WDTH+1)'(CH_NUM)) begin
            o_idx = CH_WDTH'(w_pos - (CH_WDTH+1)'(CH_NUM));
        end else begin
            o_idx = CH_WDTH'(w_pos);
        end
    end

endmodule

// File: rtl/cmip_fifo_drain_arb.sv
// Round-robin burst drain of N FWFT FIFOs into one registered valid/ready stream.
module cmip_fifo_drain_arb
    import cmip_fifo_drain_arb_pkg::*;
#(
    parameter int CH_NUM    = 32,
    parameter int DATA_WDTH = 512,
    parameter int BURST     = 16,
    parameter int CH_WDTH   = $clog2(CH_NUM),
    parameter int CNT_WDTH  = $clog2(BURST+1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    input  logic [CH_NUM-1:0]           i_ch_en,
    input  logic [CH_NUM-1:0]           i_empty,
    input  logic [CH_NUM*DATA_WDTH-1:0] i_dout,
    output logic [CH_NUM-1:0]           o_rd,
    output logic                        o_vld,
    input  logic                        i_rdy,
    output logic [DATA_WDTH-1:0]        o_data,
    output logic [CH_WDTH-1:0]          o_ch,
    output logic                        o_sop,
    output logic                        o_busy
);

    state_e               r_state;
    logic [CH_WDTH-1:0]   r_gnt;
    logic [CH_WDTH-1:0]   r_rr_ptr;
    logic [CNT_WDTH-1:0]  r_cnt;
    logic                 r_vld;
    logic                 r_sop;
    logic [DATA_WDTH-1:0] r_data;
    logic [CH_WDTH-1:0]   r_ch;

    logic [CH_NUM-1:0]    w_req;
    logic [CH_WDTH-1:0]   w_pick_idx;
    logic                 w_pick_found;
    logic                 w_in_burst;
    logic                 w_gnt_ok;
    logic                 w_ld;
    logic                 w_last;
    logic [DATA_WDTH-1:0] w_gnt_dout;

    assign w_req      = i_ch_en & ~i_empty;
    assign w_in_burst = (r_state == ST_BURST);
    assign w_gnt_ok   = i_ch_en[r_gnt] & ~i_empty[r_gnt];
    // Pop only when the output register is free or draining this cycle.
    assign w_ld       = w_in_burst & (~r_vld | i_rdy) & w_gnt_ok;
    assign w_last     = (r_cnt == CNT_WDTH'(BURST-1));

    cmip_rr_pick #(
        .CH_NUM  (CH_NUM),
        .CH_WDTH (CH_WDTH)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // Select the granted FIFO head word and steer its read strobe.
    always_comb begin
        w_gnt_dout = '0;
        o_rd       = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            w_gnt_dout = (r_gnt == CH_WDTH'(k)) ? i_dout[k*DATA_WDTH +: DATA_WDTH] : w_gnt_dout;
            o_rd[k]    = w_ld & (r_gnt == CH_WDTH'(k));
        end
    end

    // Grant FSM, burst counter and output register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_vld    <= 1'b0;
            r_sop    <= 1'b0;
            r_data   <= '0;
            r_ch     <= '0;
        end else begin
            if (w_ld) begin
                r_data <= w_gnt_dout;
                r_ch   <= r_gnt;
                r_sop  <= (r_cnt == '0);
                r_vld  <= 1'b1;
                r_cnt  <= r_cnt + CNT_WDTH'(1);
            end else if (i_rdy) begin
                r_vld  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_en && w_pick_found) begin
                        r_gnt   <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // A stalled output with data still queued keeps the grant.
                    if ((w_ld && w_last) || !w_gnt_ok) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= CH_WDTH'(rr_next(32'(r_gnt), CH_NUM));
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_ch   = r_ch;
    assign o_sop  = r_sop;
    assign o_busy = w_in_burst | r_vld;

endmodule

// File: tb/tb_cmip_fifo_drain_arb.sv
// Scoreboard bench for cmip_fifo_drain_arb with a behavioural FWFT FIFO bank.
module tb_cmip_fifo_drain_arb;

    localparam int CH    = 32;
    localparam int DW    = 32;
    localparam int BURST = 16;

    typedef struct packed {
        logic [4:0]    ch;
        logic          sop;
        logic [DW-1:0] data;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             rdy;
    logic [CH-1:0]    ch_en;
    logic [CH-1:0]    empty;
    logic [CH*DW-1:0] dout;
    logic [CH-1:0]    rd;
    logic             vld;
    logic [DW-1:0]    data;
    logic [4:0]       och;
    logic             sop;
    logic             busy;

    int   pushed [CH];
    int   popped [CH];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [4:0]    prev_ch;
    logic          prev_sop;

    function automatic logic [DW-1:0] mkword(input int c, input int s);
        return {8'(c), 8'hA5, 16'(s)};
    endfunction

    cmip_fifo_drain_arb #(
        .CH_NUM    (CH),
        .DATA_WDTH (DW),
        .BURST     (BURST)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_ch_en (ch_en),
        .i_empty (empty),
        .i_dout  (dout),
        .o_rd    (rd),
        .o_vld   (vld),
        .i_rdy   (rdy),
        .o_data  (data),
        .o_ch    (och),
        .o_sop   (sop),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        empty = '0;
        dout  = '0;
        for (int c = 0; c < CH; c++) begin
            empty[c]         = (pushed[c] == popped[c]);
            dout[c*DW +: DW] = mkword(c, popped[c]);
        end
    end

    // FIFO bank: pop on strobe, flag multi-hot strobes and underflow.
    always @(posedge clk) begin
        bit uf;
        if (|rd) begin
            uf = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (rd[c]) begin
                    if (pushed[c] == popped[c]) uf = 1'b1;
                    popped[c] <= popped[c] + 1;
                end
            end
            checks++;
            if ($countones(rd) != 1 || uf) begin
                failures++;
                $display("FAIL rd_strobe got rd=%h underflow=%0b, required one-hot to a non-empty FIFO", rd, uf);
            end
        end
    end

    // Output monitor: scoreboard compare on handshake, hold check on stall.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                checks++;
                if (data !== prev_data || och !== prev_ch || sop !== prev_sop) begin
                    failures++;
                    $display("FAIL stall_hold got ch=%0d data=%h sop=%0b, required ch=%0d data=%h sop=%0b",
                             och, data, sop, prev_ch, prev_data, prev_sop);
                end
            end
            if (vld && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra got ch=%0d data=%h, required no word", och, data);
                end else begin
                    if (och !== exp_q[0].ch || data !== exp_q[0].data || sop !== exp_q[0].sop) begin
                        failures++;
                        $display("FAIL sb_word got ch=%0d data=%h sop=%0b, required ch=%0d data=%h sop=%0b",
                                 och, data, sop, exp_q[0].ch, exp_q[0].data, exp_q[0].sop);
                    end
                    exp_q.delete(0);
                end
            end
        end
        prev_stall <= vld & ~rdy;
        prev_data  <= data;
        prev_ch    <= och;
        prev_sop   <= sop;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int c, input int n);
        pushed[c] = pushed[c] + n;
    endtask

    task automatic flush(input int c);
        pushed[c] = popped[c];
    endtask

    task automatic expect_burst(input int c, input int base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ch   = 5'(c);
            e.sop  = (i == 0);
            e.data = mkword(c, base + i);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_quiet(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        rdy   = 1'b1;
        ch_en = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vld !== 1'b0 || sop !== 1'b0 || busy !== 1'b0 || data !== '0 || och !== '0 || rd !== '0) begin
            failures++;
            $display("FAIL reset_outputs got vld=%0b sop=%0b busy=%0b data=%h ch=%0d rd=%h, required all 0",
                     vld, sop, busy, data, och, rd);
        end
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || vld !== 1'b0 || rd !== '0) begin
                failures++;
                $display("FAIL reset_idle got busy=%0b vld=%0b rd=%h, required 0", busy, vld, rd);
            end
        end
    endtask

    task automatic test_fairness();
        int fch[3] = '{0, 1, 31};
        int first = -1;
        int last  = -1;
        int n     = 0;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                expect_burst(fch[j], pushed[fch[j]] + r*16, (r < 2) ? 16 : 8);
            end
        end
        step();
        for (int j = 0; j < 3; j++) load(fch[j], 40);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (|rd) begin
                if (first < 0) first = k;
                last = k;
                n++;
            end
            if (exp_q.size() == 0 && !busy) break;
        end
        checks++;
        if (n != 120) begin
            failures++;
            $display("FAIL fair_pops got %0d, required 120", n);
        end
        // Six full-burst boundaries cost one cycle, two early-empty ones cost two.
        checks++;
        if (last - first + 1 - n != 10) begin
            failures++;
            $display("FAIL fair_gaps got %0d idle cycles, required 10", last - first + 1 - n);
        end
        wait_quiet(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fair_drain got %0d words pending, required 0 and idle", exp_q.size());
        end
    endtask

    task automatic test_single();
        int rd_k[$];
        int first_vld = -1;
        bit other     = 1'b0;
        bit ok;
        expect_burst(3, pushed[3], 16);
        expect_burst(3, pushed[3] + 16, 4);
        step();
        load(3, 20);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rd[3]) rd_k.push_back(k);
            if ((rd & ~(32'd1 << 3)) != '0) other = 1'b1;
            if (vld && first_vld < 0) first_vld = k;
        end
        checks++;
        if (rd_k.size() != 20 || other) begin
            failures++;
            $display("FAIL single_pops got %0d on ch3 other=%0b, required 20 and 0", rd_k.size(), other);
        end
        checks++;
        if (rd_k.size() == 0 || rd_k[0] != 1 || first_vld != 2) begin
            failures++;
            $display("FAIL single_latency got rd@%0d vld@%0d, required rd@1 vld@2",
                     (rd_k.size() > 0) ? rd_k[0] : -1, first_vld);
        end
        checks++;
        if (rd_k.size() < 17 || rd_k[15] != 16 || rd_k[16] != 18) begin
            failures++;
            $display("FAIL single_gap got 16th/17th pop at %0d/%0d, required 16/18",
                     (rd_k.size() > 15) ? rd_k[15] : -1, (rd_k.size() > 16) ? rd_k[16] : -1);
        end
        wait_quiet(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_drain got %0d words pending, required 0 and idle", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int b      = pushed[5];
        int stalls = 0;
        bit ok;
        expect_burst(5, b, 10);
        step();
        load(5, 10);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (vld && !rdy) stalls++;
            if (exp_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
            rdy = ~rdy;
        end
        rdy = 1'b1;
        checks++;
        if (stalls == 0) begin
            failures++;
            $display("FAIL bp_stalls got 0 stall cycles, required at least 1");
        end
        wait_quiet(20, ok);
        checks++;
        if (!ok || popped[5] - b != 10) begin
            failures++;
            $display("FAIL bp_drain got %0d pops %0d pending, required 10 pops 0 pending", popped[5] - b, exp_q.size());
        end
    endtask

    task automatic test_early_empty();
        int n7      = 0;
        bit other   = 1'b0;
        logic busy4 = 1'b0;
        logic busy5 = 1'b1;
        bit ok;
        expect_burst(7, pushed[7], 3);
        step();
        load(7, 3);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rd[7]) n7++;
            if ((rd & ~(32'd1 << 7)) != '0) other = 1'b1;
            if (k == 4) busy4 = busy;
            if (k == 5) busy5 = busy;
        end
        checks++;
        if (n7 != 3 || other) begin
            failures++;
            $display("FAIL early_pops got %0d other=%0b, required 3 and 0", n7, other);
        end
        checks++;
        if (busy4 !== 1'b1 || busy5 !== 1'b0) begin
            failures++;
            $display("FAIL early_end got busy %0b/%0b at cycles 4/5, required 1/0", busy4, busy5);
        end
        wait_quiet(20, ok);
        // Pointer now sits at 8, so ch8 outranks ch7.
        expect_burst(8, pushed[8], 1);
        expect_burst(7, pushed[7], 1);
        step();
        load(7, 1);
        load(8, 1);
        wait_quiet(30, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL early_ptr got %0d words pending, required 0 and idle", exp_q.size());
        end
    endtask

    task automatic test_enable_mask();
        int b;
        int late = 0;
        bit ok;
        step();
        en = 1'b0;
        for (int c = 0; c < CH; c++) load(c, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (rd !== '0 || vld !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL en_off got rd=%h vld=%0b busy=%0b, required 0", rd, vld, busy);
            end
        end
        step();
        for (int c = 0; c < CH; c++) flush(c);
        en = 1'b1;
        step();
        b = pushed[2];
        expect_burst(2, b, 3);
        load(2, 10);
        repeat (4) @(posedge clk);
        #1;
        ch_en[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd != '0) late++;
        end
        checks++;
        if (late != 0 || popped[2] - b != 3) begin
            failures++;
            $display("FAIL mask_stop got %0d late strobes %0d pops, required 0 and 3", late, popped[2] - b);
        end
        wait_quiet(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mask_drain got %0d words pending, required 0 and idle", exp_q.size());
        end
        flush(2);
        ch_en = '1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        expect_burst(12, pushed[12], 4);
        step();
        load(12, 20);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        flush(12);
        expect_burst(0, pushed[0], 1);
        expect_burst(31, pushed[31], 1);
        load(0, 1);
        load(31, 1);
        @(negedge clk);
        checks++;
        if (vld !== 1'b0 || sop !== 1'b0 || busy !== 1'b0 || data !== '0 || och !== '0 || rd !== '0) begin
            failures++;
            $display("FAIL rst_mid got vld=%0b sop=%0b busy=%0b data=%h ch=%0d rd=%h, required all 0",
                     vld, sop, busy, data, och, rd);
        end
        wait_quiet(30, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_restart got %0d words pending, required 0 and idle", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_early_empty();
        test_enable_mask();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
